// File: rtl/apb_pkg.sv
// Shared types and widths for the APB completer register block.
package apb_pkg;

   typedef enum logic [0:0] {CMP_IDLE, CMP_ACCESS} apb_cmp_state_t;

   localparam int unsigned APB_DATA_W = 32;
   localparam int unsigned APB_STRB_W = 4;

endpackage

// File: rtl/apb_cmp_regbank.sv
// Register storage behind the APB completer: RW words with byte-lane merge, a read mux and a
// read-only transfer counter held in the last word of the window.
module apb_cmp_regbank
   import apb_pkg::*;
#(
   parameter int unsigned NUM_REGS = 8
) (
   input  logic                  clk,
   input  logic                  preset_n,
   input  logic                  we_i,
   input  logic [5:0]            idx_i,
   input  logic [APB_DATA_W-1:0] wdata_i,
   input  logic [APB_STRB_W-1:0] wstrb_i,
   input  logic                  cnt_en_i,
   output logic [APB_DATA_W-1:0] rdata_o
);

   localparam int unsigned NumRw = NUM_REGS - 1;

   logic [APB_DATA_W-1:0] regs_q [NumRw];
   logic [APB_DATA_W-1:0] regs_d [NumRw];
   logic [APB_DATA_W-1:0] cnt_q, cnt_d;

   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NumRw; i++) begin
         if (we_i && (idx_i == 6'(i))) begin
            for (int b = 0; b < APB_STRB_W; b++) begin
               if (wstrb_i[b]) begin
                  regs_d[i][8*b +: 8] = wdata_i[8*b +: 8];
               end
            end
         end
      end
      cnt_d = cnt_en_i ? cnt_q + 32'd1 : cnt_q;
   end

   // Counter is read from the register, so a read of it sees the pre-increment value.
   always_comb begin
      rdata_o = '0;
      if (idx_i == 6'(NumRw)) begin
         rdata_o = cnt_q;
      end
      for (int i = 0; i < NumRw; i++) begin
         if (idx_i == 6'(i)) begin
            rdata_o = regs_q[i];
         end
      end
   end

   always_ff @(posedge clk or negedge preset_n) begin
      if (!preset_n) begin
         regs_q <= '{default: '0};
         cnt_q  <= '0;
      end else begin
         regs_q <= regs_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: rtl/apb_completer_regs.sv
// APB completer: decodes one register window, inserts fixed wait states, flags illegal accesses
// with pslverr and records initiator protocol violations in a sticky flag.
module apb_completer_regs
   import apb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = 32'h0000_A000,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  preset_n,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [31:0]           paddr,
   input  logic [APB_DATA_W-1:0] pwdata,
   input  logic [APB_STRB_W-1:0] pstrb,
   output logic [APB_DATA_W-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   output logic                  proto_err
);

   localparam logic [31:0] WinBytes = 32'(NUM_REGS * 4);
   localparam logic [5:0]  CntIdx   = 6'(NUM_REGS - 1);
   localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);

   apb_cmp_state_t        state_q, state_d;
   logic [3:0]            wait_cnt_q, wait_cnt_d;
   logic                  proto_err_q, proto_err_d;
   logic [31:0]           offset;
   logic                  addr_ok;
   logic [5:0]            idx;
   logic                  acc_err;
   logic                  complete;
   logic [APB_DATA_W-1:0] bank_rdata;

   always_comb begin
      offset  = paddr - BASE_ADDR;
      addr_ok = (paddr >= BASE_ADDR) && (paddr[1:0] == 2'b00) && (offset < WinBytes);
      idx     = offset[7:2];
      acc_err = !addr_ok || (pwrite && (idx == CntIdx));
   end

   always_comb begin
      state_d     = state_q;
      wait_cnt_d  = wait_cnt_q;
      proto_err_d = proto_err_q;
      complete    = 1'b0;
      case (state_q)
         CMP_IDLE: begin
            if (psel && !penable) begin
               wait_cnt_d = WaitInit;
               state_d    = CMP_ACCESS;
            end else if (psel && penable) begin
               proto_err_d = 1'b1;
            end
         end
         CMP_ACCESS: begin
            if (!psel || !penable) begin
               proto_err_d = 1'b1;
               state_d     = CMP_IDLE;
            end else if (wait_cnt_q != 4'd0) begin
               wait_cnt_d = wait_cnt_q - 4'd1;
            end else begin
               complete = 1'b1;
               state_d  = CMP_IDLE;
            end
         end
         default: state_d = CMP_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge preset_n) begin
      if (!preset_n) begin
         state_q     <= CMP_IDLE;
         wait_cnt_q  <= '0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         proto_err_q <= proto_err_d;
      end
   end

   always_comb begin
      pready    = complete;
      pslverr   = complete && acc_err;
      prdata    = (complete && !pwrite && !acc_err) ? bank_rdata : '0;
      proto_err = proto_err_q;
   end

   apb_cmp_regbank #(
      .NUM_REGS (NUM_REGS)
   ) u_regbank (
      .clk      (clk),
      .preset_n (preset_n),
      .we_i     (complete && pwrite && !acc_err),
      .idx_i    (idx),
      .wdata_i  (pwdata),
      .wstrb_i  (pstrb),
      .cnt_en_i (complete && !acc_err),
      .rdata_o  (bank_rdata)
   );

endmodule

// File: tb/tb_apb_completer_regs.sv
// Randomized bench for apb_completer_regs: one instance with one wait state, one with none,
// both checked against a word-array model of the register window.
module tb_apb_completer_regs;

   localparam logic [31:0] Base = 32'h0000_A000;

   logic        clk = 1'b0;
   logic        preset_n = 1'b0;
   logic        psel_a = 1'b0, psel_b = 1'b0, penable = 1'b0, pwrite = 1'b0;
   logic [31:0] paddr = '0, pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b, proto_a, proto_b;

   int n_checks = 0;
   int n_errors = 0;

   // Model: words 0..6 RW, word 7 the counter; index 0 = one-wait DUT, 1 = zero-wait DUT.
   logic [31:0] mreg [2][8];
   logic        mproto [2];
   logic [31:0] last_rd;
   logic        last_err;

   always #5 clk = ~clk;

   apb_completer_regs #(.BASE_ADDR(Base), .NUM_REGS(8), .WAIT_CYCLES(1)) dut_a (
      .clk(clk), .preset_n(preset_n), .psel(psel_a), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_a), .pready(pready_a),
      .pslverr(pslverr_a), .proto_err(proto_a)
   );

   apb_completer_regs #(.BASE_ADDR(Base), .NUM_REGS(8), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .preset_n(preset_n), .psel(psel_b), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata_b), .pready(pready_b),
      .pslverr(pslverr_b), .proto_err(proto_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) mreg[d][i] = '0;
         mproto[d] = 1'b0;
      end
   endtask

   task automatic model_access(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb,
                               output logic e_err, output logic [31:0] e_rd);
      longint unsigned off = longint'(addr) - longint'(Base);
      bit legal = (addr >= Base) && (addr % 4 == 0) && (off < 32);
      int k = int'(off / 4);
      e_err = 1'b0;
      e_rd  = '0;
      if (!legal || (wr && k == 7)) begin
         e_err = 1'b1;
      end else begin
         if (wr) begin
            for (int b = 0; b < 4; b++)
               if (strb[b]) mreg[d][k][8*b +: 8] = data[8*b +: 8];
         end else begin
            e_rd = mreg[d][k];
         end
         mreg[d][7] = mreg[d][7] + 1;
      end
   endtask

   function automatic logic [31:0] rdy(input int d);
      return d == 0 ? 32'(pready_a) : 32'(pready_b);
   endfunction

   function automatic logic [31:0] perr(input int d);
      return d == 0 ? 32'(proto_a) : 32'(proto_b);
   endfunction

   task automatic idle();
      @(negedge clk);
      psel_a = 1'b0; psel_b = 1'b0; penable = 1'b0;
   endtask

   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
      int w = (d == 0) ? 1 : 0;
      logic        e_err;
      logic [31:0] e_rd;
      @(negedge clk);
      psel_a = (d == 0); psel_b = (d == 1); penable = 1'b0;
      pwrite = wr; paddr = addr; pwdata = data; pstrb = strb;
      #1;
      check("setup_pready", rdy(d), 0);
      check("proto_err", perr(d), 32'(mproto[d]));
      for (int k = 0; k <= w; k++) begin
         @(negedge clk);
         penable = 1'b1;
         #1;
         if (k < w) begin
            check("wait_pready", rdy(d), 0);
         end else begin
            model_access(d, wr, addr, data, strb, e_err, e_rd);
            last_rd  = (d == 0) ? prdata_a : prdata_b;
            last_err = (d == 0) ? pslverr_a : pslverr_b;
            check("done_pready", rdy(d), 1);
            check("pslverr", 32'(last_err), 32'(e_err));
            check("prdata", last_rd, e_rd);
         end
      end
   endtask

   function automatic logic [31:0] rand_addr();
      int r = $urandom_range(0, 11);
      if (r < 8) return Base + 32'(4 * r);
      case (r)
         8:       return Base + 32'd32 + 32'(4 * $urandom_range(0, 8));
         9:       return Base - 32'(4 * $urandom_range(1, 4));
         10:      return Base + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] bad_addr [4];
      model_clear();
      #1;
      check("rst_pready", 32'(pready_a), 0);
      check("rst_pslverr", 32'(pslverr_a), 0);
      check("rst_prdata", prdata_a, 0);
      check("rst_proto", 32'(proto_a), 0);
      repeat (2) @(negedge clk);
      preset_n = 1'b1;

      // Counter starts from zero after reset.
      xfer(0, 1'b1, Base, 32'h1111_1111, 4'hF);
      xfer(0, 1'b1, Base + 32'h8, 32'h2222_2222, 4'hF);
      xfer(0, 1'b0, Base + 32'h8, 32'h0, 4'h0);
      xfer(0, 1'b0, Base + 32'h1C, 32'h0, 4'h0);
      check("cnt_first", last_rd, 32'd3);
      xfer(0, 1'b0, Base + 32'h1C, 32'h0, 4'h0);
      check("cnt_second", last_rd, 32'd4);

      // Write/read and byte-strobe merge.
      xfer(0, 1'b1, Base + 32'h4, 32'hDEAD_BEEF, 4'hF);
      xfer(0, 1'b0, Base + 32'h4, 32'h0, 4'h0);
      check("wr_rd", last_rd, 32'hDEAD_BEEF);
      xfer(0, 1'b1, Base + 32'h4, 32'h1234_5678, 4'b0011);
      xfer(0, 1'b0, Base + 32'h4, 32'h0, 4'h0);
      check("strb_merge", last_rd, 32'hDEAD_5678);

      // Error responses, including a write to the read-only counter.
      bad_addr = '{Base + 32'h20, Base - 32'h4, Base + 32'h2, Base + 32'h1C};
      for (int i = 0; i < 4; i++) begin
         xfer(0, 1'b1, bad_addr[i], 32'hFFFF_FFFF, 4'hF);
         check("err_wr", 32'(last_err), 1);
         if (i < 3) begin
            xfer(0, 1'b0, bad_addr[i], 32'h0, 4'h0);
            check("err_rd", 32'(last_err), 1);
         end
      end
      xfer(0, 1'b0, Base + 32'h1C, 32'h0, 4'h0);
      check("cnt_after_err", last_rd, 32'd9);

      // Random traffic on both instances, sometimes back-to-back.
      for (int n = 0; n < 300; n++) begin
         xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), rand_addr(), $urandom,
              4'($urandom));
         if ($urandom_range(0, 3) == 0) idle();
      end

      // Zero-wait back-to-back writes.
      xfer(1, 1'b1, Base + 32'h8, 32'hCAFE_0001, 4'hF);
      xfer(1, 1'b1, Base + 32'hC, 32'hCAFE_0002, 4'hF);
      xfer(1, 1'b0, Base + 32'hC, 32'h0, 4'h0);
      check("b2b_rd", last_rd, 32'hCAFE_0002);

      // Abort mid-access on the one-wait instance.
      idle();
      @(negedge clk);
      psel_a = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = Base + 32'h10;
      pwdata = 32'h5A5A_5A5A; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      penable = 1'b0;
      #1;
      check("abort_pready", 32'(pready_a), 0);
      @(negedge clk);
      psel_a = 1'b0;
      mproto[0] = 1'b1;
      #1;
      check("abort_proto", 32'(proto_a), 1);
      xfer(0, 1'b0, Base + 32'h10, 32'h0, 4'h0);

      // Access phase with no setup on the zero-wait instance.
      idle();
      @(negedge clk);
      psel_b = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = Base;
      #1;
      check("nosetup_pready", 32'(pready_b), 0);
      @(negedge clk);
      psel_b = 1'b0; penable = 1'b0;
      mproto[1] = 1'b1;
      #1;
      check("nosetup_proto", 32'(proto_b), 1);
      xfer(1, 1'b0, Base, 32'h0, 4'h0);

      // Reset asserted in the completing cycle drops the write and clears everything.
      @(negedge clk);
      psel_b = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = Base + 32'h4;
      pwdata = 32'h7777_7777; pstrb = 4'hF;
      @(negedge clk);
      penable = 1'b1;
      #1;
      check("pre_rst_pready", 32'(pready_b), 1);
      #1 preset_n = 1'b0;
      #1;
      check("rst_mid_pready", 32'(pready_b), 0);
      check("rst_mid_prdata", prdata_b, 0);
      check("rst_mid_proto", 32'(proto_b), 0);
      psel_b = 1'b0; penable = 1'b0;
      @(negedge clk);
      preset_n = 1'b1;
      model_clear();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 8; i++) begin
            xfer(d, 1'b0, Base + 32'(4 * i), 32'h0, 4'h0);
            if (i < 7) check("post_rst_reg", last_rd, 0);
         end
      end
      check("post_rst_cnt", last_rd, 32'd7);
      idle();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_completer_regs.md
# apb_completer_regs

APB completer (slave) terminating the APB side of the AHB-to-APB bridge. It decodes one register window starting at `BASE_ADDR` (default 0xA000, the bridge's APB target address) and backs it with a small read/write register bank. It inserts a programmable number of wait states, signals `pslverr` on illegal accesses, and keeps a read-only counter of completed transfers, so the bridge's initiator FSM can be exercised end to end.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_A000: byte address of register 0.
- `NUM_REGS`, 8: number of 32-bit words in the window, range 2..64. The last word is the read-only transfer counter; the rest are RW.
- `WAIT_CYCLES`, 1: wait states per transfer, range 0..15.

Ports:
- `clk`, in, 1: clock.
- `preset_n`, in, 1: reset, asynchronous, active-low.
- `psel`, in, 1: select.
- `penable`, in, 1: access phase.
- `pwrite`, in, 1: 1 = write, 0 = read.
- `paddr`, in, 32: byte address.
- `pwdata`, in, 32: write data.
- `pstrb`, in, 4: write byte strobes; bit i enables `pwdata[8i+7:8i]`.
- `prdata`, out, 32: read data. Valid only when `pready` is 1 and `pwrite` is 0; 0 otherwise.
- `pready`, out, 1: transfer completes this cycle.
- `pslverr`, out, 1: error response. Valid only with `pready`.
- `proto_err`, out, 1: sticky flag for an initiator protocol violation. Cleared only by reset.

## Operation
FSM states: `CMP_IDLE`, `CMP_ACCESS`.
- **`CMP_IDLE`**:
  - `psel=1` and `penable=0` (setup phase): load `wait_cnt` with `WAIT_CYCLES`, go to `CMP_ACCESS`.
  - `psel=1` and `penable=1` with no preceding setup: set `proto_err`, stay in `CMP_IDLE`, no response.
- **`CMP_ACCESS`**:
  - `psel=0` or `penable=0`: abort. Set `proto_err`, no write, go to `CMP_IDLE`.
  - `psel=1`, `penable=1`, `wait_cnt!=0`: decrement `wait_cnt`, `pready=0`.
  - `psel=1`, `penable=1`, `wait_cnt==0`: `pready=1`, commit the transfer at this edge, go to `CMP_IDLE`.

Decode:
- `offset = paddr - BASE_ADDR`, computed in 32-bit unsigned.
- Address is legal when `paddr >= BASE_ADDR`, `paddr[1:0] == 0`, and `offset < NUM_REGS*4`.
- `idx = offset[7:2]`.

Completion rules:
- **Illegal address:** `pslverr=1`, `prdata=0`, no register change, counter not incremented.
- **Write to counter index (`NUM_REGS-1`):** `pslverr=1`, no change, counter not incremented.
- **Legal write:** each byte lane with `pstrb[i]=1` updates. `pstrb=0` is a legal no-op write and still counts.
- **Legal read:** `prdata` = register value. For the counter index this is the pre-increment value.
- **Counter:** increments by 1 on every completion with `pslverr=0`. 32-bit, wraps from 0xFFFF_FFFF to 0.
- `paddr`, `pwrite`, `pwdata` and `pstrb` are sampled in the completing cycle. APB requires them stable from setup through completion; the completer does not check this.

Reset (asynchronous, any time including mid-transfer):
- State goes to `CMP_IDLE`.
- All RW registers, the counter and `proto_err` go to 0.
- `pready`, `pslverr` and `prdata` go to 0.
- An in-flight write is dropped.

## Timing
- `pready`, `pslverr` and `prdata` are combinational from state, `wait_cnt` and the decode of the current address. No registered output delay.
- Transfer length is 2 + `WAIT_CYCLES` cycles: 1 setup plus `WAIT_CYCLES+1` access.
  - `WAIT_CYCLES=0`: `pready` is 1 in the first access cycle.
- Write data is visible to a read whose setup phase starts the cycle after completion.
- Back-to-back transfers: the completion cycle returns to `CMP_IDLE`. A setup phase in the very next cycle is accepted with no idle gap.
- No throughput limit other than wait states: one transfer per 2 + `WAIT_CYCLES` cycles.

## Structure
- Package `apb_pkg` holds:
  - `typedef enum logic [0:0] {CMP_IDLE, CMP_ACCESS} apb_cmp_state_t`;
  - `APB_DATA_W = 32`;
  - `APB_STRB_W = 4`.
- Sub-module `apb_cmp_regbank` contains the RW registers, strobe merge, read mux and transfer counter. Its ports are: write enable, index, data, strobe, count enable, read data.
- The top level holds the FSM, wait counter, address decode and error logic.

## Test plan
Parameters for all scenarios: `BASE_ADDR=0xA000`, `NUM_REGS=8`, `WAIT_CYCLES=1` unless stated.

1. **Write then read:** write 0xA004, data 0xDEADBEEF, `pstrb=0xF`. `pready` rises in the 2nd access cycle, `pslverr=0`. Read 0xA004 returns 0xDEADBEEF.
2. **Byte strobes:** with reg1 = 0xDEADBEEF, write 0x12345678 with `pstrb=4'b0011`. Reading 0xA004 returns 0xDEAD5678.
3. **Error responses:** reads/writes to 0xA020, 0x9FFC and 0xA002, and a write to 0xA01C, each give `pready=1`, `pslverr=1`, `prdata=0`, with no register change. Reading 0xA01C afterwards returns only the count of the earlier good transfers.
4. **Counter:** after reset, 3 good transfers, then a read of 0xA01C returns 3. A second read returns 4.
5. **Zero wait and back-to-back:** with `WAIT_CYCLES=0`, two writes with setup phases separated by exactly one access cycle each take 2 cycles, and both complete.
6. **Violations and reset:**
   - Dropping `penable` mid-access sets `proto_err`, leaves the register unchanged, returns to idle, and the next transfer works.
   - Asserting `preset_n=0` during an access cycle immediately forces `pready=0`, and all registers read 0 afterwards.
